// File: rtl/time_ascii_sender.sv
// time_ascii_sender: serialises a snapshot of hour/min/sec/centisecond
// inputs as the ASCII frame "HH:MM:SS.CC" towards a byte-wide UART
// transmitter. Each character uses a start/busy handshake. CHAR_GAP idle
// cycles are inserted between characters.
// Optional feature macro: TIME_SENDER_CRLF_EN appends CR LF to the frame.
module time_ascii_sender #(
  parameter int unsigned CHAR_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_send,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       i_tx_busy,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_done
);

`ifdef TIME_SENDER_CRLF_EN
  localparam int unsigned FRAME_LEN = 13;
`else
  localparam int unsigned FRAME_LEN = 11;
`endif
  localparam logic [3:0]  LAST_IDX  = 4'(FRAME_LEN - 1);
  localparam int unsigned GAP_LAST  = (CHAR_GAP == 0) ? 0 : CHAR_GAP - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q,   idx_d;
  logic [31:0] gap_q,   gap_d;
  logic [4:0]  hour_q,  hour_d;
  logic [5:0]  min_q,   min_d;
  logic [5:0]  sec_q,   sec_d;
  logic [6:0]  msec_q,  msec_d;
  logic [7:0]  data_q,  data_d;
  logic        load_chr;
  logic [7:0]  nxt_chr;

  // Field values above 99 are shown as "99".
  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [7:0] tens_chr(input logic [6:0] v);
    logic [6:0] c;
    c = clamp99(v);
    return 8'h30 + {1'b0, c / 7'd10};
  endfunction

  function automatic logic [7:0] ones_chr(input logic [6:0] v);
    logic [6:0] c;
    c = clamp99(v);
    return 8'h30 + {1'b0, c % 7'd10};
  endfunction

  // Character lookup for the index about to be presented on o_tx_data.
  always_comb begin
    nxt_chr = 8'h00;
    case (idx_d)
      4'd0:    nxt_chr = tens_chr({2'b00, hour_q});
      4'd1:    nxt_chr = ones_chr({2'b00, hour_q});
      4'd2:    nxt_chr = 8'h3A;
      4'd3:    nxt_chr = tens_chr({1'b0, min_q});
      4'd4:    nxt_chr = ones_chr({1'b0, min_q});
      4'd5:    nxt_chr = 8'h3A;
      4'd6:    nxt_chr = tens_chr({1'b0, sec_q});
      4'd7:    nxt_chr = ones_chr({1'b0, sec_q});
      4'd8:    nxt_chr = 8'h2E;
      4'd9:    nxt_chr = tens_chr(msec_q);
      4'd10:   nxt_chr = ones_chr(msec_q);
`ifdef TIME_SENDER_CRLF_EN
      4'd11:   nxt_chr = 8'h0D;
      4'd12:   nxt_chr = 8'h0A;
`endif
      default: nxt_chr = 8'h00;
    endcase
  end

  // Frame sequencing: next state, index/gap bookkeeping and strobes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    msec_d     = msec_q;
    load_chr   = 1'b0;
    o_tx_start = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_send) begin
          state_d = S_LOAD;
          idx_d   = '0;
          hour_d  = hour;
          min_d   = min;
          sec_d   = sec;
          msec_d  = msec;
        end
      end
      S_LOAD: begin
        o_busy   = 1'b1;
        load_chr = 1'b1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        o_busy = 1'b1;
        if (!i_tx_busy) begin
          o_tx_start = 1'b1;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        o_busy = 1'b1;
        if (i_tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        o_busy = 1'b1;
        if (!i_tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + 4'd1;
            load_chr = 1'b1;
            if (CHAR_GAP == 0) begin
              state_d = S_SEND;
            end else begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end
        end
      end
      S_GAP: begin
        o_busy = 1'b1;
        if (gap_q == GAP_LAST) state_d = S_SEND;
        else                   gap_d   = gap_q + 32'd1;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset masks the strobes in the reset cycle itself so an abort emits nothing more.
    if (rst) begin
      o_tx_start = 1'b0;
      o_busy     = 1'b0;
      o_done     = 1'b0;
    end
  end

  // Outgoing byte register: reloaded only when the character index moves.
  always_comb begin
    data_d = load_chr ? nxt_chr : data_q;
  end

  assign o_tx_data = data_q;

  // State, index, gap counter, snapshot and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      msec_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      msec_q  <= msec_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: doc/time_ascii_sender.md
TIME_ASCII_SENDER -- requirements
Module: time_ascii_sender

Interface
REQ-001 SHALL have parameter CHAR_GAP, default 0, meaning idle clk cycles inserted between successive characters.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_send  input  1  request to transmit one time frame; level or pulse.
REQ-005 SHALL have port msec  input  7  centiseconds, 0..99.
REQ-006 SHALL have port sec  input  6  seconds, 0..59.
REQ-007 SHALL have port min  input  6  minutes, 0..59.
REQ-008 SHALL have port hour  input  5  hours, 0..23.
REQ-009 SHALL have port i_tx_busy  input  1  downstream UART transmitter busy flag.
REQ-010 SHALL have port o_tx_start  output  1  one-cycle start strobe to the UART transmitter.
REQ-011 SHALL have port o_tx_data  output  8  ASCII byte, valid whenever o_tx_start=1.
REQ-012 SHALL have port o_busy  output  1  high from frame acceptance through o_done.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse when the last character completes.

Function
REQ-014 SHALL emit the frame "HH:MM:SS.CC" (11 bytes, MSB digit first) built from hour, min, sec, msec.
REQ-015 SHALL encode each digit as 0x30+value; separators SHALL be 0x3A (':') and 0x2E ('.').
REQ-016 SHALL split each field into tens = v/10 and ones = v%10; any field value >99 SHALL clamp to "99".
REQ-017 SHALL accept i_send only in IDLE; acceptance SHALL snapshot all four time inputs in that same cycle.
REQ-018 SHALL ignore input changes after the snapshot; the frame always reflects the snapshot.
REQ-019 SHALL ignore i_send while o_busy=1; no queuing of requests.
REQ-020 SHALL implement states IDLE -> LOAD -> SEND -> WAIT_ACK -> WAIT_DONE -> (GAP) -> SEND ... -> DONE -> IDLE.
REQ-021 In SEND, SHALL assert o_tx_start for exactly one cycle, and only when i_tx_busy=0; otherwise SHALL hold in SEND.
REQ-022 In WAIT_ACK, SHALL wait for i_tx_busy=1, then in WAIT_DONE SHALL wait for i_tx_busy=0 before advancing the character index.
REQ-023 SHALL insert CHAR_GAP idle cycles after each character except the last; CHAR_GAP=0 SHALL skip GAP.
REQ-024 SHALL keep o_tx_data stable from the o_tx_start cycle until the character index advances.
REQ-025 After the last character's WAIT_DONE, SHALL enter DONE, pulse o_done for one cycle, drop o_busy in the same cycle, and return to IDLE.
REQ-026 SHALL accept a new i_send in the cycle after o_done, giving back-to-back frames.
REQ-027 First o_tx_start SHALL occur 2 cycles after acceptance (LOAD, then SEND) when i_tx_busy=0.

Reset
REQ-028 On rst=1, SHALL go to IDLE with o_tx_start=0, o_tx_data=0x00, o_busy=0, o_done=0, character index 0, snapshot cleared.
REQ-029 rst mid-frame SHALL abort the frame immediately with no further o_tx_start and no o_done.
REQ-030 rst SHALL take priority over i_send in the same cycle.

Configuration
REQ-031 Macro TIME_SENDER_CRLF_EN SHALL, when defined, append 0x0D 0x0A to the frame (13 bytes); o_done SHALL follow the 0x0A.
REQ-032 Without TIME_SENDER_CRLF_EN, the frame SHALL be exactly 11 bytes, ending with the ones digit of msec.

Verification
REQ-033 hour=1,min=2,sec=3,msec=45, pulse i_send, model UART busy 10 cycles per byte -> bytes 30 31 3A 30 32 3A 30 33 2E 34 35, then one o_done.
REQ-034 Change all inputs to 23:59:59.99 one cycle after acceptance -> frame still "01:02:03.45".
REQ-035 Hold i_send=1 for the entire frame -> exactly one frame until o_done, then a second frame starts in the next cycle.
REQ-036 msec=127, hour=23 -> last digits "99", first digits "23".
REQ-037 Assert rst after the 4th o_tx_start -> no further o_tx_start, o_busy=0, o_done never pulses; next i_send sends a full frame.
REQ-038 Build with TIME_SENDER_CRLF_EN -> 13 o_tx_start strobes ending 0D 0A; without it -> 11 strobes.
